seq_scan_ctrl: RTL and testbench

Controller that sequences a serial pattern detector over parallel words. It accepts a WORD_W-bit word and a programmable pattern through a valid/ready handshake, then shifts the word MSB-first through an internal Mealy-style pattern matcher, one bit per clock. It counts matches in overlapping or non-overlapping mode and returns the match count and first-match position through a second valid/ready handshake. It sits between a word-oriented producer and the serial detection datapath, generalising the fixed "101" Mealy detector.

---
 rtl/seq_scan_pkg.sv | 18 +
 rtl/seq_pattern_match.sv | 66 ++++++
 rtl/seq_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and sizing helpers for the serial pattern scan controller.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_PAT_W  = 3;

    // Width needed to hold 0..w inclusive (counts and the "no match" position).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_match.sv
// Serial Mealy matcher: history shift register, fill counter and masked compare
// of the newest pat_len bits against the programmed pattern.
module seq_pattern_match
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    output logic             match
);

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic             enough;
    logic             equal;

    if (PAT_W > 1) begin : g_hist
        logic [PAT_W-2:0] hist;

        always_ff @(posedge clk) begin
            if (reset || clear) begin
                hist <= '0;
            end else if (bit_valid) begin
                hist <= window[PAT_W-2:0];
            end
        end

        assign window = {hist, bit_in};
    end else begin : g_nohist
        assign window = bit_in;
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(pat_len));
        end
    end

    // fill counts valid history bits; fill+1 includes the bit being scanned.
    assign enough = ({1'b0, fill} + 1'b1) >= {1'b0, pat_len};
    assign equal  = ((window ^ pattern) & mask) == '0;
    assign match  = bit_valid && (pat_len != '0) && enough && equal;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fill <= '0;
        end else if (bit_valid) begin
            if (match && !overlap) begin
                fill <= '0;
            end else if (fill != LEN_W'(PAT_W)) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level controller: accepts a word and pattern, scans it MSB-first through
// the serial matcher and returns match count and first match position.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = cnt_width(WORD_W)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [WORD_W-1:0]            word_in,
    input  logic [PAT_W-1:0]             pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   pat_len,
    input  logic                         overlap,
    output logic                         busy,
    output logic                         bit_out,
    output logic                         match_pulse,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [CNT_W-1:0]             match_count,
    output logic [CNT_W-1:0]             first_pos
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] NONE = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    state_t            state;
    state_t            state_nx;
    logic [WORD_W-1:0] word_q;
    logic [PAT_W-1:0]  pattern_q;
    logic [LEN_W-1:0]  pat_len_q;
    logic              overlap_q;
    logic [CNT_W-1:0]  k_q;
    logic              accept;
    logic              match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        start_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        bit_out      = 1'b0;
        accept       = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                accept      = start_valid && !reset;
                if (start_valid) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                busy    = 1'b1;
                bit_out = word_q[WORD_W-1];
                if (k_q == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign match_pulse = match;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q      <= '0;
            pattern_q   <= '0;
            pat_len_q   <= '0;
            overlap_q   <= 1'b0;
            k_q         <= '0;
            match_count <= '0;
            first_pos   <= NONE;
        end else if (accept) begin
            word_q      <= word_in;
            pattern_q   <= pattern;
            pat_len_q   <= pat_len;
            overlap_q   <= overlap;
            k_q         <= '0;
            match_count <= '0;
            first_pos   <= NONE;
        end else if (busy) begin
            word_q <= {word_q[WORD_W-2:0], 1'b0};
            k_q    <= k_q + 1'b1;
            if (match) begin
                match_count <= match_count + 1'b1;
                if (first_pos == NONE) begin
                    first_pos <= k_q;
                end
            end
        end
    end

    seq_pattern_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .bit_valid (busy),
        .bit_in    (bit_out),
        .pattern   (pattern_q),
        .pat_len   (pat_len_q),
        .overlap   (overlap_q),
        .match     (match)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl with hand-computed match masks per word.
module tb_seq_scan_ctrl;

    localparam int WORD_W = 16;
    localparam int PAT_W  = 3;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_valid;
    logic              start_ready;
    logic [WORD_W-1:0] word_in;
    logic [PAT_W-1:0]  pattern;
    logic [1:0]        pat_len;
    logic              overlap;
    logic              busy;
    logic              bit_out;
    logic              match_pulse;
    logic              result_valid;
    logic              result_ready;
    logic [CNT_W-1:0]  match_count;
    logic [CNT_W-1:0]  first_pos;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(
        .WORD_W (WORD_W),
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .word_in      (word_in),
        .pattern      (pattern),
        .pat_len      (pat_len),
        .overlap      (overlap),
        .busy         (busy),
        .bit_out      (bit_out),
        .match_pulse  (match_pulse),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .match_count  (match_count),
        .first_pos    (first_pos)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, ".start_ready"}, start_ready, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".bit_out"}, bit_out, 0);
        chk({tag, ".match_pulse"}, match_pulse, 0);
        chk({tag, ".result_valid"}, result_valid, 0);
    endtask

    // Accept a word, check every scanned bit, finish in DONE with result checked.
    task automatic scan(input string tag, input logic [15:0] w,
                        input logic [2:0] p, input logic [1:0] len,
                        input logic ov, input logic [15:0] exp_mask,
                        input int exp_cnt, input int exp_first);
        word_in     = w;
        pattern     = p;
        pat_len     = len;
        overlap     = ov;
        start_valid = 1'b1;
        chk({tag, ".start_ready"}, start_ready, 1);
        tick();
        start_valid = 1'b0;
        word_in     = ~w;
        pattern     = ~p;
        pat_len     = ~len;
        overlap     = ~ov;
        for (int k = 0; k < WORD_W; k++) begin
            chk({tag, ".busy"}, busy, 1);
            chk({tag, $sformatf(".bit%0d", k)}, bit_out, w[WORD_W-1-k]);
            chk({tag, $sformatf(".match%0d", k)}, match_pulse, exp_mask[k]);
            chk({tag, ".no_result"}, result_valid, 0);
            tick();
        end
        chk({tag, ".result_valid"}, result_valid, 1);
        chk({tag, ".busy_done"}, busy, 0);
        chk({tag, ".start_ready_done"}, start_ready, 0);
        chk({tag, ".match_count"}, match_count, exp_cnt);
        chk({tag, ".first_pos"}, first_pos, exp_first);
    endtask

    task automatic release_result(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        idle_outputs({tag, ".after_release"});
    endtask

    localparam logic [15:0] W0 = 16'b0101_0100_1101_0100;

    initial begin
        reset        = 1'b1;
        start_valid  = 1'b1;
        word_in      = W0;
        pattern      = 3'b101;
        pat_len      = 2'd3;
        overlap      = 1'b1;
        result_ready = 1'b0;
        tick();
        tick();
        idle_outputs("reset");
        chk("reset.match_count", match_count, 0);
        chk("reset.first_pos", first_pos, 16);
        reset       = 1'b0;
        start_valid = 1'b0;
        tick();
        idle_outputs("post_reset");

        scan("ovl", W0, 3'b101, 2'd3, 1'b1, 16'h2828, 4, 3);
        release_result("ovl");

        scan("novl", W0, 3'b101, 2'd3, 1'b0, 16'h0808, 2, 3);
        release_result("novl");

        scan("len0", W0, 3'b101, 2'd0, 1'b1, 16'h0000, 0, 16);
        release_result("len0");

        scan("zero", 16'h0000, 3'b101, 2'd3, 1'b1, 16'h0000, 0, 16);
        release_result("zero");

        scan("ones", 16'hFFFF, 3'b001, 2'd1, 1'b0, 16'hFFFF, 16, 0);

        // Stall in DONE with start activity; nothing may move.
        for (int i = 0; i < 5; i++) begin
            start_valid = ~start_valid;
            word_in     = 16'(i * 16'h1357);
            pattern     = 3'(i);
            tick();
            chk("hold.result_valid", result_valid, 1);
            chk("hold.start_ready", start_ready, 0);
            chk("hold.busy", busy, 0);
            chk("hold.match_count", match_count, 16);
            chk("hold.first_pos", first_pos, 0);
        end
        start_valid = 1'b0;
        release_result("hold");
        scan("after_hold", W0, 3'b101, 2'd3, 1'b1, 16'h2828, 4, 3);
        release_result("after_hold");

        // Abort mid-scan at k=7.
        word_in     = W0;
        pattern     = 3'b101;
        pat_len     = 2'd3;
        overlap     = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("abort.busy_k7", busy, 1);
        chk("abort.bit_k7", bit_out, W0[8]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_outputs("abort");
        chk("abort.match_count", match_count, 0);
        chk("abort.first_pos", first_pos, 16);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort.no_result", result_valid, 0);
        end
        scan("clean", W0, 3'b101, 2'd3, 1'b1, 16'h2828, 4, 3);
        release_result("clean");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
